lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
Load/store sequencer between the ALU->LSU pipeline boundary and the data-memory port. It accepts one memory operation from the ALU stage, drives a req/gnt/rvalid bus transaction, and asserts a stall to freeze the upstream pipeline registers until the access completes. It generates byte enables and lane-replicated write data, and sign- or zero-extends load data for write-back. It also flags misaligned accesses and bus timeouts.

Parameters:
BUS_TIMEOUT, 16, number of cycles spent waiting in REQ or WAIT before the access is aborted (range 2..255).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
alu_mem_req_i  input  1  ALU stage presents a valid load/store this cycle
alu_mem_we_i  input  1  1 = store, 0 = load
alu_mem_size_i  input  2  00 byte, 01 half, 10 word, 11 treated as word
alu_mem_unsigned_i  input  1  zero-extend loads (LBU/LHU)
alu_mem_addr_i  input  32  byte address
alu_mem_wdata_i  input  32  store data, right-aligned
alu_rd_reg_addr_i  input  5  load destination register
dmem_req_o  output  1  bus request
dmem_we_o  output  1  bus write
dmem_addr_o  output  32  word-aligned address ({addr[31:2],2'b00})
dmem_be_o  output  4  byte enables
dmem_wdata_o  output  32  lane-replicated store data
dmem_gnt_i  input  1  request accepted
dmem_rvalid_i  input  1  response valid (read data, or write acknowledge)
dmem_rdata_i  input  32  read data
lsu_stall_o  output  1  hold upstream stages and the ALU->LSU register
lsu_load_valid_o  output  1  one-cycle pulse: load result valid
lsu_load_data_o  output  32  extended load result
lsu_load_rd_o  output  5  load destination register
lsu_misalign_o  output  1  one-cycle pulse: misaligned access rejected
lsu_bus_err_o  output  1  one-cycle pulse: bus timeout abort

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset: state IDLE and timeout counter 0. All outputs are 0, including load_data and load_rd. An assertion mid-transaction drops the pending operation immediately and lsu_stall_o falls asynchronously. The bus slave is expected to be reset by the same rst_n.
- States: IDLE, REQ, WAIT.
- IDLE:
  - On alu_mem_req_i with an aligned address: capture we, size, unsigned, addr[1:0], rd and formatted bus fields into registers, then go to REQ.
  - lsu_stall_o is driven combinationally high in that same cycle.
- Misaligned check (IDLE only):
  - half with addr[0]=1, or word with addr[1:0]!=0, is rejected.
  - Result: no bus request, state stays IDLE, no stall, lsu_misalign_o pulses high the next cycle.
- REQ:
  - dmem_req_o=1. addr, we, be and wdata are held stable until gnt.
  - On dmem_gnt_i go to WAIT. gnt in the first REQ cycle is legal.
  - dmem_rvalid_i is ignored in REQ.
- WAIT:
  - dmem_req_o=0.
  - On dmem_rvalid_i go to IDLE.
  - For a load, register the extended data and rd and pulse lsu_load_valid_o the next cycle. Stores produce no load_valid.
- Stall: lsu_stall_o = (state!=IDLE) OR (IDLE AND accepting a request). It is low in the cycle after the rvalid cycle.
  - Minimum occupancy for gnt-immediately plus rvalid-next: stall is high for 3 cycles (accept, REQ, WAIT).
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<addr[1:0]
  - word: 4'b1111
- Write data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load extract: select the lane using the captured addr[1:0]. Byte/half results are sign-extended unless unsigned=1; word results are passed through.
- Timeout:
  - The counter clears on entering REQ and increments each REQ/WAIT cycle; it does not reset between REQ and WAIT.
  - When it reaches BUS_TIMEOUT without completion: go to IDLE, drop dmem_req_o, pulse lsu_bus_err_o the next cycle, no load_valid.
- Output registers: lsu_load_data_o and lsu_load_rd_o hold their last value between pulses. A load to rd=0 still pulses valid; write-back ignores x0.
- Back-to-back: a new request is accepted only in IDLE. Because upstream is stalled, the next op presents the cycle after stall falls.

Test Plan:
- LW at 0x1000, gnt in cycle 1, rvalid in cycle 2 with rdata 0xDEADBEEF, rd=5 -> dmem_addr 0x1000, be 1111, stall high 3 cycles, load_valid pulse with data 0xDEADBEEF, rd 5.
- LB at 0x2003 with rdata 0x80xxxxxx -> be 1000, load_data 0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH at 0x3002 with wdata 0x0000ABCD -> dmem_wdata 0xABCDABCD, be 1100, we=1. gnt delayed 3 cycles keeps req/addr stable. No load_valid.
- LW at 0x4001 -> no dmem_req, no stall, misalign pulse one cycle later, state IDLE.
- Request with gnt never asserted, BUS_TIMEOUT=16 -> req drops after 16 cycles, bus_err pulses once, stall falls, next request accepted normally.
- rst_n low during WAIT -> stall and req drop immediately, no load_valid after release, fresh LW completes correctly.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between the ALU->LSU boundary and a req/gnt/rvalid data-memory port.
// Formats byte enables and store data, extends load data, and reports misalignment and bus timeouts.
module lsu_mem_ctrl #(
  parameter int BUS_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_mem_req_i,
  input  logic        alu_mem_we_i,
  input  logic [1:0]  alu_mem_size_i,
  input  logic        alu_mem_unsigned_i,
  input  logic [31:0] alu_mem_addr_i,
  input  logic [31:0] alu_mem_wdata_i,
  input  logic [4:0]  alu_rd_reg_addr_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        lsu_stall_o,
  output logic        lsu_load_valid_o,
  output logic [31:0] lsu_load_data_o,
  output logic [4:0]  lsu_load_rd_o,
  output logic        lsu_misalign_o,
  output logic        lsu_bus_err_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [7:0] TIMEOUT_LAST = 8'(BUS_TIMEOUT - 1);

  logic [1:0]  state_reg;
  logic [7:0]  timer_reg;
  logic        we_reg;
  logic [1:0]  size_reg;
  logic        unsigned_reg;
  logic [1:0]  lane_reg;
  logic [4:0]  rd_reg;
  logic [31:0] addr_reg;
  logic [3:0]  be_reg;
  logic [31:0] wdata_reg;
  logic        load_valid_reg;
  logic [31:0] load_data_reg;
  logic [4:0]  load_rd_reg;
  logic        misalign_reg;
  logic        bus_err_reg;

  logic        misaligned;
  logic        accept;
  logic [3:0]  be_fmt;
  logic [31:0] wdata_fmt;
  logic [31:0] rdata_shifted;
  logic [31:0] load_ext;

  assign misaligned = ((alu_mem_size_i == 2'b01) && alu_mem_addr_i[0]) ||
                      (alu_mem_size_i[1] && (alu_mem_addr_i[1:0] != 2'b00));
  // rst_n gates acceptance so stall is low for the whole reset assertion.
  assign accept = rst_n && (state_reg == IDLE) && alu_mem_req_i && !misaligned;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign be_fmt[gi] = (alu_mem_size_i == 2'b00) ? (alu_mem_addr_i[1:0] == LANE) :
                          (alu_mem_size_i == 2'b01) ? (alu_mem_addr_i[1] == LANE[1]) : 1'b1;
      assign wdata_fmt[gi*8 +: 8] = (alu_mem_size_i == 2'b00) ? alu_mem_wdata_i[7:0] :
                                    (alu_mem_size_i == 2'b01) ? alu_mem_wdata_i[(gi%2)*8 +: 8] :
                                                                alu_mem_wdata_i[gi*8 +: 8];
    end
  endgenerate

  assign rdata_shifted = dmem_rdata_i >> {lane_reg, 3'b000};

  always_comb begin
    load_ext = dmem_rdata_i;
    case (size_reg)
      2'b00:   load_ext = {{24{~unsigned_reg & rdata_shifted[7]}}, rdata_shifted[7:0]};
      2'b01:   load_ext = {{16{~unsigned_reg & rdata_shifted[15]}}, rdata_shifted[15:0]};
      default: load_ext = dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      timer_reg      <= '0;
      we_reg         <= 1'b0;
      size_reg       <= 2'b00;
      unsigned_reg   <= 1'b0;
      lane_reg       <= 2'b00;
      rd_reg         <= '0;
      addr_reg       <= '0;
      be_reg         <= '0;
      wdata_reg      <= '0;
      load_valid_reg <= 1'b0;
      load_data_reg  <= '0;
      load_rd_reg    <= '0;
      misalign_reg   <= 1'b0;
      bus_err_reg    <= 1'b0;
    end else begin
      load_valid_reg <= 1'b0;
      misalign_reg   <= 1'b0;
      bus_err_reg    <= 1'b0;
      case (state_reg)
        IDLE: begin
          misalign_reg <= alu_mem_req_i && misaligned;
          if (accept) begin
            we_reg       <= alu_mem_we_i;
            size_reg     <= alu_mem_size_i;
            unsigned_reg <= alu_mem_unsigned_i;
            lane_reg     <= alu_mem_addr_i[1:0];
            rd_reg       <= alu_rd_reg_addr_i;
            addr_reg     <= {alu_mem_addr_i[31:2], 2'b00};
            be_reg       <= be_fmt;
            wdata_reg    <= wdata_fmt;
            timer_reg    <= '0;
            state_reg    <= REQ;
          end
        end
        REQ: begin
          // The timeout wins over a grant arriving in the final allowed cycle.
          if (timer_reg == TIMEOUT_LAST) begin
            state_reg   <= IDLE;
            bus_err_reg <= 1'b1;
          end else begin
            timer_reg <= timer_reg + 8'd1;
            if (dmem_gnt_i) state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (dmem_rvalid_i) begin
            state_reg <= IDLE;
            if (!we_reg) begin
              load_valid_reg <= 1'b1;
              load_data_reg  <= load_ext;
              load_rd_reg    <= rd_reg;
            end
          end else if (timer_reg == TIMEOUT_LAST) begin
            state_reg   <= IDLE;
            bus_err_reg <= 1'b1;
          end else begin
            timer_reg <= timer_reg + 8'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign dmem_req_o       = (state_reg == REQ);
  assign dmem_we_o        = we_reg;
  assign dmem_addr_o      = addr_reg;
  assign dmem_be_o        = be_reg;
  assign dmem_wdata_o     = wdata_reg;
  assign lsu_stall_o      = (state_reg != IDLE) || accept;
  assign lsu_load_valid_o = load_valid_reg;
  assign lsu_load_data_o  = load_data_reg;
  assign lsu_load_rd_o    = load_rd_reg;
  assign lsu_misalign_o   = misalign_reg;
  assign lsu_bus_err_o    = bus_err_reg;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: a vector table of single operations plus
// hand-written sequences for delayed grant, timeout and mid-transaction reset.
module tb_lsu_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        alu_mem_req_i;
  logic        alu_mem_we_i;
  logic [1:0]  alu_mem_size_i;
  logic        alu_mem_unsigned_i;
  logic [31:0] alu_mem_addr_i;
  logic [31:0] alu_mem_wdata_i;
  logic [4:0]  alu_rd_reg_addr_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        lsu_stall_o;
  logic        lsu_load_valid_o;
  logic [31:0] lsu_load_data_o;
  logic [4:0]  lsu_load_rd_o;
  logic        lsu_misalign_o;
  logic        lsu_bus_err_o;

  int pass_count = 0;
  int total_count = 0;

  lsu_mem_ctrl #(.BUS_TIMEOUT(16)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .alu_mem_req_i      (alu_mem_req_i),
    .alu_mem_we_i       (alu_mem_we_i),
    .alu_mem_size_i     (alu_mem_size_i),
    .alu_mem_unsigned_i (alu_mem_unsigned_i),
    .alu_mem_addr_i     (alu_mem_addr_i),
    .alu_mem_wdata_i    (alu_mem_wdata_i),
    .alu_rd_reg_addr_i  (alu_rd_reg_addr_i),
    .dmem_req_o         (dmem_req_o),
    .dmem_we_o          (dmem_we_o),
    .dmem_addr_o        (dmem_addr_o),
    .dmem_be_o          (dmem_be_o),
    .dmem_wdata_o       (dmem_wdata_o),
    .dmem_gnt_i         (dmem_gnt_i),
    .dmem_rvalid_i      (dmem_rvalid_i),
    .dmem_rdata_i       (dmem_rdata_i),
    .lsu_stall_o        (lsu_stall_o),
    .lsu_load_valid_o   (lsu_load_valid_o),
    .lsu_load_data_o    (lsu_load_data_o),
    .lsu_load_rd_o      (lsu_load_rd_o),
    .lsu_misalign_o     (lsu_misalign_o),
    .lsu_bus_err_o      (lsu_bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        exp_misalign;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_load;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_count++;
    if (act === exp) pass_count++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    alu_mem_req_i = 1'b0;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = 32'h0;
  endtask

  task automatic present(input vec_t v);
    alu_mem_req_i      = 1'b1;
    alu_mem_we_i       = v.we;
    alu_mem_size_i     = v.size;
    alu_mem_unsigned_i = v.uns;
    alu_mem_addr_i     = v.addr;
    alu_mem_wdata_i    = v.wdata;
    alu_rd_reg_addr_i  = v.rd;
  endtask

  // One op with gnt in the first REQ cycle and rvalid in the following cycle.
  task automatic run_op(input vec_t v);
    present(v);
    #1;
    check({v.name, " accept_stall"}, 32'(lsu_stall_o), 32'(!v.exp_misalign));
    check({v.name, " accept_noreq"}, 32'(dmem_req_o), 32'd0);
    tick;
    alu_mem_req_i = 1'b0;
    if (v.exp_misalign) begin
      #1;
      check({v.name, " misalign_pulse"}, 32'(lsu_misalign_o), 32'd1);
      check({v.name, " misalign_noreq"}, 32'(dmem_req_o), 32'd0);
      check({v.name, " misalign_nostall"}, 32'(lsu_stall_o), 32'd0);
      tick;
      check({v.name, " misalign_once"}, 32'(lsu_misalign_o), 32'd0);
    end else begin
      dmem_gnt_i = 1'b1;
      #1;
      check({v.name, " req"}, 32'(dmem_req_o), 32'd1);
      check({v.name, " we"}, 32'(dmem_we_o), 32'(v.we));
      check({v.name, " addr"}, dmem_addr_o, v.exp_addr);
      check({v.name, " be"}, 32'(dmem_be_o), 32'(v.exp_be));
      check({v.name, " wdata"}, dmem_wdata_o, v.exp_wdata);
      check({v.name, " req_stall"}, 32'(lsu_stall_o), 32'd1);
      tick;
      dmem_gnt_i    = 1'b0;
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = v.rdata;
      #1;
      check({v.name, " wait_noreq"}, 32'(dmem_req_o), 32'd0);
      check({v.name, " wait_stall"}, 32'(lsu_stall_o), 32'd1);
      tick;
      dmem_rvalid_i = 1'b0;
      #1;
      check({v.name, " done_stall"}, 32'(lsu_stall_o), 32'd0);
      check({v.name, " load_valid"}, 32'(lsu_load_valid_o), 32'(!v.we));
      if (!v.we) begin
        check({v.name, " load_data"}, lsu_load_data_o, v.exp_load);
        check({v.name, " load_rd"}, 32'(lsu_load_rd_o), 32'(v.rd));
      end
      tick;
      check({v.name, " valid_once"}, 32'(lsu_load_valid_o), 32'd0);
    end
  endtask

  initial begin
    int n;
    //          name     we    size   uns   addr          wdata         rd    rdata         mis   exp_addr      be       exp_wdata     exp_load
    vecs[0]  = '{"LW",    1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h1234_5678, 5'd5, 32'hDEAD_BEEF, 1'b0, 32'h0000_1000, 4'b1111, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[1]  = '{"LB",    1'b0, 2'b00, 1'b0, 32'h0000_2003, 32'h0000_00AA, 5'd7, 32'h8012_3456, 1'b0, 32'h0000_2000, 4'b1000, 32'hAAAA_AAAA, 32'hFFFF_FF80};
    vecs[2]  = '{"LBU",   1'b0, 2'b00, 1'b1, 32'h0000_2003, 32'h0000_00AA, 5'd8, 32'h8012_3456, 1'b0, 32'h0000_2000, 4'b1000, 32'hAAAA_AAAA, 32'h0000_0080};
    vecs[3]  = '{"LH_hi", 1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_0000, 5'd9, 32'h8001_1234, 1'b0, 32'h0000_2000, 4'b1100, 32'h0000_0000, 32'hFFFF_8001};
    vecs[4]  = '{"LH_lo", 1'b0, 2'b01, 1'b0, 32'h0000_2000, 32'h0000_0000, 5'd10, 32'h1234_F00D, 1'b0, 32'h0000_2000, 4'b0011, 32'h0000_0000, 32'hFFFF_F00D};
    vecs[5]  = '{"LHU",   1'b0, 2'b01, 1'b1, 32'h0000_2000, 32'h0000_0000, 5'd11, 32'h1234_F00D, 1'b0, 32'h0000_2000, 4'b0011, 32'h0000_0000, 32'h0000_F00D};
    vecs[6]  = '{"SB",    1'b1, 2'b00, 1'b0, 32'h0000_5001, 32'h0000_00C3, 5'd12, 32'h0000_0000, 1'b0, 32'h0000_5000, 4'b0010, 32'hC3C3_C3C3, 32'h0};
    vecs[7]  = '{"SW",    1'b1, 2'b10, 1'b0, 32'h0000_6000, 32'hCAFE_F00D, 5'd13, 32'h0000_0000, 1'b0, 32'h0000_6000, 4'b1111, 32'hCAFE_F00D, 32'h0};
    vecs[8]  = '{"LB_pos",1'b0, 2'b00, 1'b0, 32'h0000_7001, 32'h0000_0000, 5'd14, 32'h0000_7F00, 1'b0, 32'h0000_7000, 4'b0010, 32'h0000_0000, 32'h0000_007F};
    vecs[9]  = '{"LW_sz3",1'b0, 2'b11, 1'b0, 32'h0000_8000, 32'h0000_0000, 5'd1, 32'h89AB_CDEF, 1'b0, 32'h0000_8000, 4'b1111, 32'h0000_0000, 32'h89AB_CDEF};
    vecs[10] = '{"LW_mis",1'b0, 2'b10, 1'b0, 32'h0000_4001, 32'h0000_0000, 5'd2, 32'h0000_0000, 1'b1, 32'h0, 4'b0, 32'h0, 32'h0};
    vecs[11] = '{"LH_mis",1'b0, 2'b01, 1'b0, 32'h0000_4003, 32'h0000_0000, 5'd3, 32'h0000_0000, 1'b1, 32'h0, 4'b0, 32'h0, 32'h0};

    rst_n = 1'b0;
    idle_inputs();
    alu_mem_we_i = 1'b0; alu_mem_size_i = 2'b00; alu_mem_unsigned_i = 1'b0;
    alu_mem_addr_i = 32'h0; alu_mem_wdata_i = 32'h0; alu_rd_reg_addr_i = 5'd0;
    tick;
    tick;
    check("reset_stall", 32'(lsu_stall_o), 32'd0);
    check("reset_req", 32'(dmem_req_o), 32'd0);
    check("reset_be", 32'(dmem_be_o), 32'd0);
    check("reset_load_valid", 32'(lsu_load_valid_o), 32'd0);
    check("reset_load_data", lsu_load_data_o, 32'd0);
    check("reset_load_rd", 32'(lsu_load_rd_o), 32'd0);
    check("reset_misalign", 32'(lsu_misalign_o), 32'd0);
    check("reset_bus_err", 32'(lsu_bus_err_o), 32'd0);
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 12; i++) run_op(vecs[i]);

    // Load to x0 still pulses valid.
    run_op('{"LW_x0", 1'b0, 2'b10, 1'b0, 32'h0000_9004, 32'h0, 5'd0, 32'h0000_0001, 1'b0, 32'h0000_9004, 4'b1111, 32'h0, 32'h0000_0001});
    check("hold_load_data", lsu_load_data_o, 32'h0000_0001);

    // SH with grant delayed three cycles.
    present('{"SH", 1'b1, 2'b01, 1'b0, 32'h0000_3002, 32'h0000_ABCD, 5'd4, 32'h0, 1'b0, 32'h0, 4'b0, 32'h0, 32'h0});
    tick;
    alu_mem_req_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("SH_hold_req", 32'(dmem_req_o), 32'd1);
      check("SH_hold_addr", dmem_addr_o, 32'h0000_3000);
      check("SH_hold_be", 32'(dmem_be_o), 32'b1100);
      check("SH_hold_wdata", dmem_wdata_o, 32'hABCD_ABCD);
      check("SH_hold_we", 32'(dmem_we_o), 32'd1);
      tick;
    end
    dmem_gnt_i = 1'b1;
    tick;
    dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b1;
    tick;
    dmem_rvalid_i = 1'b0;
    #1;
    check("SH_no_load_valid", 32'(lsu_load_valid_o), 32'd0);
    check("SH_done_stall", 32'(lsu_stall_o), 32'd0);
    tick;

    // Grant never arrives: abort after 16 REQ cycles.
    present(vecs[0]);
    tick;
    alu_mem_req_i = 1'b0;
    n = 0;
    while (dmem_req_o && n < 40) begin
      n++;
      tick;
    end
    check("timeout_req_cycles", 32'(n), 32'd16);
    check("timeout_bus_err", 32'(lsu_bus_err_o), 32'd1);
    check("timeout_stall", 32'(lsu_stall_o), 32'd0);
    check("timeout_no_valid", 32'(lsu_load_valid_o), 32'd0);
    tick;
    check("timeout_err_once", 32'(lsu_bus_err_o), 32'd0);
    run_op(vecs[1]);

    // Reset asserted while waiting for rvalid.
    present(vecs[0]);
    tick;
    alu_mem_req_i = 1'b0;
    dmem_gnt_i = 1'b1;
    tick;
    dmem_gnt_i = 1'b0;
    #1;
    check("rst_wait_stall_before", 32'(lsu_stall_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_stall", 32'(lsu_stall_o), 32'd0);
    check("rst_async_req", 32'(dmem_req_o), 32'd0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    check("rst_no_valid", 32'(lsu_load_valid_o), 32'd0);
    check("rst_idle_stall", 32'(lsu_stall_o), 32'd0);
    tick;
    run_op(vecs[0]);

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
